// File: rtl/register_file_mp.sv
// Parametrised register bank: two prioritised write ports, combinational read
// ports with optional write bypass, and a per-register busy scoreboard.
module register_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [XLEN-1:0]          wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [XLEN-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*XLEN-1:0]   rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int unsigned NREG  = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] busy_cnt_d;

    logic wr0_en;
    logic wr1_en;
    logic set_en;
    logic clr0;
    logic clr1;

    // Next-state for storage, busy vector and busy counter.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;

        wr0_en = we0 && !(ZERO_REG && (waddr0 == '0));
        wr1_en = we1 && !(ZERO_REG && (waddr1 == '0));

        // A set only counts when the bit is currently clear; a clear only
        // counts when the bit is set and no same-address set overrides it.
        set_en = sb_set && !(ZERO_REG && (sb_addr == '0)) && !busy_q[sb_addr];
        clr0   = we0 && busy_q[waddr0] && !(sb_set && (sb_addr == waddr0));
        clr1   = we1 && busy_q[waddr1] && !(sb_set && (sb_addr == waddr1))
                 && !(clr0 && (waddr1 == waddr0));

        if (wr0_en) regs_d[waddr0] = wdata0;
        if (wr1_en) regs_d[waddr1] = wdata1;

        if (clr0)   busy_d[waddr0]  = 1'b0;
        if (clr1)   busy_d[waddr1]  = 1'b0;
        if (set_en) busy_d[sb_addr] = 1'b1;

        busy_cnt_d = busy_cnt_q + CNT_W'(set_en) - CNT_W'(clr0) - CNT_W'(clr1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;

    // Read ports: zero register, then port 1 bypass, port 0 bypass, storage.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        hit0  = 1'b0;
        hit1  = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra   = raddr[i*ADDR_W +: ADDR_W];
            hit1 = BYPASS && we1 && (waddr1 == ra);
            hit0 = BYPASS && we0 && (waddr0 == ra);
            if (!reset_n || (ZERO_REG && (ra == '0))) begin
                rdata[i*XLEN +: XLEN] = '0;
                rbusy[i]              = 1'b0;
            end else begin
                if (hit1) begin
                    rdata[i*XLEN +: XLEN] = wdata1;
                end else if (hit0) begin
                    rdata[i*XLEN +: XLEN] = wdata0;
                end else begin
                    rdata[i*XLEN +: XLEN] = regs_q[ra];
                end
                rbusy[i] = busy_q[ra] && !hit1 && !hit0;
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

    // The up/down counter must always track the population of the busy vector.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (busy_cnt_q == CNT_W'($countones(busy_q)));
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default configuration plus a 4-port, 64-bit,
// no-bypass instance, both checked against a behavioural model every cycle.
module tb_register_file_mp;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    localparam int unsigned NRD [2] = '{2, 4};
    localparam bit          BYP [2] = '{1'b1, 1'b0};

    logic        we0_s    [2];
    logic        we1_s    [2];
    logic        sb_set_s [2];
    logic [4:0]  waddr0_s [2];
    logic [4:0]  waddr1_s [2];
    logic [4:0]  sb_addr_s[2];
    logic [63:0] wdata0_s [2];
    logic [63:0] wdata1_s [2];
    logic [4:0]  raddr_s  [2][4];

    logic [63:0]  rdata_a;
    logic [1:0]   rbusy_a;
    logic [5:0]   cnt_a;
    logic [255:0] rdata_b;
    logic [3:0]   rbusy_b;
    logic [4:0]   cnt_b;

    register_file_mp u_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .we0      (we0_s[0]),
        .waddr0   (waddr0_s[0]),
        .wdata0   (wdata0_s[0][31:0]),
        .we1      (we1_s[0]),
        .waddr1   (waddr1_s[0]),
        .wdata1   (wdata1_s[0][31:0]),
        .raddr    ({raddr_s[0][1], raddr_s[0][0]}),
        .rdata    (rdata_a),
        .rbusy    (rbusy_a),
        .sb_set   (sb_set_s[0]),
        .sb_addr  (sb_addr_s[0]),
        .busy_cnt (cnt_a)
    );

    register_file_mp #(
        .XLEN(64), .ADDR_W(4), .NUM_RD(4), .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) u_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .we0      (we0_s[1]),
        .waddr0   (waddr0_s[1][3:0]),
        .wdata0   (wdata0_s[1]),
        .we1      (we1_s[1]),
        .waddr1   (waddr1_s[1][3:0]),
        .wdata1   (wdata1_s[1]),
        .raddr    ({raddr_s[1][3][3:0], raddr_s[1][2][3:0],
                    raddr_s[1][1][3:0], raddr_s[1][0][3:0]}),
        .rdata    (rdata_b),
        .rbusy    (rbusy_b),
        .sb_set   (sb_set_s[1]),
        .sb_addr  (sb_addr_s[1][3:0]),
        .busy_cnt (cnt_b)
    );

    // Behavioural model state: register contents and busy flags per instance.
    logic [63:0] m_regs [2][32];
    logic        m_busy [2][32];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_rdata(input int k, input int p);
        logic [4:0] a;
        a = raddr_s[k][p];
        if (!reset_n || a == 5'd0) return 64'd0;
        if (BYP[k] && we1_s[k] && waddr1_s[k] == a) return wdata1_s[k];
        if (BYP[k] && we0_s[k] && waddr0_s[k] == a) return wdata0_s[k];
        return m_regs[k][a];
    endfunction

    function automatic logic exp_rbusy(input int k, input int p);
        logic [4:0] a;
        a = raddr_s[k][p];
        if (!reset_n || a == 5'd0) return 1'b0;
        if (BYP[k] && ((we1_s[k] && waddr1_s[k] == a) || (we0_s[k] && waddr0_s[k] == a)))
            return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [63:0] exp_cnt(input int k);
        int n;
        n = 0;
        if (!reset_n) return 64'd0;
        for (int r = 0; r < 32; r++) if (m_busy[k][r]) n++;
        return 64'(n);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                for (int r = 0; r < 32; r++) begin
                    m_regs[k][r] = 64'd0;
                    m_busy[k][r] = 1'b0;
                end
            end else begin
                if (we0_s[k] && waddr0_s[k] != 5'd0) m_regs[k][waddr0_s[k]] = wdata0_s[k];
                if (we1_s[k] && waddr1_s[k] != 5'd0) m_regs[k][waddr1_s[k]] = wdata1_s[k];
                if (we0_s[k]) m_busy[k][waddr0_s[k]] = 1'b0;
                if (we1_s[k]) m_busy[k][waddr1_s[k]] = 1'b0;
                if (sb_set_s[k] && sb_addr_s[k] != 5'd0) m_busy[k][sb_addr_s[k]] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] act_d;
        logic        act_b;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < int'(NRD[k]); p++) begin
                act_d = (k == 0) ? {32'd0, rdata_a[p*32 +: 32]} : rdata_b[p*64 +: 64];
                act_b = (k == 0) ? rbusy_a[p] : rbusy_b[p];
                chk($sformatf("u%0d.rdata[%0d] addr %0d", k, p, raddr_s[k][p]), act_d, exp_rdata(k, p));
                chk($sformatf("u%0d.rbusy[%0d] addr %0d", k, p, raddr_s[k][p]),
                    64'(act_b), 64'(exp_rbusy(k, p)));
            end
            chk($sformatf("u%0d.busy_cnt", k), (k == 0) ? 64'(cnt_a) : 64'(cnt_b), exp_cnt(k));
        end
    endtask

    task automatic step();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            we0_s[k] = 1'b0; we1_s[k] = 1'b0; sb_set_s[k] = 1'b0;
            waddr0_s[k] = 5'd0; waddr1_s[k] = 5'd0; sb_addr_s[k] = 5'd0;
            wdata0_s[k] = 64'd0; wdata1_s[k] = 64'd0;
            for (int p = 0; p < 4; p++) raddr_s[k][p] = 5'd0;
        end
    endtask

    function automatic logic [4:0] rnd_addr(input int k);
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, (k == 0) ? 31 : 15));
    endfunction

    initial begin
        reset_n = 1'b0;
        idle();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                m_regs[k][r] = 64'd0;
                m_busy[k][r] = 1'b0;
            end
        #1;
        chk("reset_rdata_a", rdata_a, 64'd0);
        chk("reset_cnt_a", 64'(cnt_a), 64'd0);
        step();
        reset_n = 1'b1;

        // Asynchronous reset clears data and scoreboard without an edge.
        we0_s[0] = 1'b1; waddr0_s[0] = 5'd5; wdata0_s[0] = 64'hDEADBEEF;
        sb_set_s[0] = 1'b1; sb_addr_s[0] = 5'd7;
        step();
        idle(); raddr_s[0][0] = 5'd5; raddr_s[0][1] = 5'd7;
        #1;
        chk("pre_reset_r5", 64'(rdata_a[31:0]), 64'hDEADBEEF);
        chk("pre_reset_rbusy", 64'(rbusy_a), 64'h2);
        chk("pre_reset_cnt", 64'(cnt_a), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_r5", 64'(rdata_a[31:0]), 64'd0);
        chk("async_reset_rbusy", 64'(rbusy_a), 64'd0);
        chk("async_reset_cnt", 64'(cnt_a), 64'd0);
        step();
        reset_n = 1'b1;

        // Same-address write conflict: port 1 wins, also on the bypass path.
        we0_s[0] = 1'b1; waddr0_s[0] = 5'd3; wdata0_s[0] = 64'h11111111;
        we1_s[0] = 1'b1; waddr1_s[0] = 5'd3; wdata1_s[0] = 64'h22222222;
        raddr_s[0][0] = 5'd3;
        #2;
        chk("conflict_bypass", 64'(rdata_a[31:0]), 64'h22222222);
        step();
        idle(); raddr_s[0][0] = 5'd3;
        #1;
        chk("conflict_stored", 64'(rdata_a[31:0]), 64'h22222222);

        // Register 0 is neither writable nor markable busy.
        idle();
        we1_s[0] = 1'b1; waddr1_s[0] = 5'd0; wdata1_s[0] = 64'hFFFFFFFF;
        sb_set_s[0] = 1'b1; sb_addr_s[0] = 5'd0;
        #1;
        chk("zero_rdata_bypass", rdata_a, 64'd0);
        chk("zero_rbusy", 64'(rbusy_a), 64'd0);
        step();
        idle();
        #1;
        chk("zero_rdata_stored", rdata_a, 64'd0);
        chk("zero_cnt", 64'(cnt_a), 64'd0);

        // Scoreboard set, then writeback forwards and clears.
        sb_set_s[0] = 1'b1; sb_addr_s[0] = 5'd9;
        step();
        idle(); raddr_s[0][0] = 5'd9;
        #1;
        chk("sb_r9_busy", 64'(rbusy_a[0]), 64'd1);
        chk("sb_cnt_1", 64'(cnt_a), 64'd1);
        we1_s[0] = 1'b1; waddr1_s[0] = 5'd9; wdata1_s[0] = 64'hA5A5A5A5;
        #1;
        chk("sb_r9_fwd_busy", 64'(rbusy_a[0]), 64'd0);
        chk("sb_r9_fwd_data", 64'(rdata_a[31:0]), 64'hA5A5A5A5);
        step();
        idle();
        #1;
        chk("sb_cnt_0", 64'(cnt_a), 64'd0);

        // Simultaneous set and clear.
        sb_set_s[0] = 1'b1; sb_addr_s[0] = 5'd4;
        step();
        we0_s[0] = 1'b1; waddr0_s[0] = 5'd4; wdata0_s[0] = 64'h44;
        sb_set_s[0] = 1'b1; sb_addr_s[0] = 5'd4;
        step();
        idle(); raddr_s[0][0] = 5'd4;
        #1;
        chk("setwin_r4_busy", 64'(rbusy_a[0]), 64'd1);
        chk("setwin_cnt", 64'(cnt_a), 64'd1);
        we0_s[0] = 1'b1; waddr0_s[0] = 5'd4; wdata0_s[0] = 64'h45;
        sb_set_s[0] = 1'b1; sb_addr_s[0] = 5'd6; raddr_s[0][1] = 5'd6;
        step();
        idle(); raddr_s[0][0] = 5'd4; raddr_s[0][1] = 5'd6;
        #1;
        chk("netzero_rbusy", 64'(rbusy_a), 64'h2);
        chk("netzero_cnt", 64'(cnt_a), 64'd1);
        step();

        // Wide no-bypass instance: fill all registers, read them back.
        idle();
        for (int i = 0; i < 8; i++) begin
            we0_s[1] = 1'b1; waddr0_s[1] = 5'(2*i);   wdata0_s[1] = 64'hC0DE_0000_0000_0000 | 64'(2*i);
            we1_s[1] = 1'b1; waddr1_s[1] = 5'(2*i+1); wdata1_s[1] = 64'hC0DE_0000_0000_0000 | 64'(2*i+1);
            step();
        end
        idle();
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) raddr_s[1][p] = 5'(4*c + p);
            step();
        end
        idle();
        we0_s[1] = 1'b1; waddr0_s[1] = 5'd2; wdata0_s[1] = 64'h0123_4567_89AB_CDEF;
        raddr_s[1][0] = 5'd2; raddr_s[1][1] = 5'd0; raddr_s[1][2] = 5'd15;
        #1;
        chk("nobyp_old_r2", rdata_b[63:0], 64'hC0DE_0000_0000_0002);
        chk("nobyp_r0", rdata_b[127:64], 64'd0);
        chk("nobyp_r15", rdata_b[191:128], 64'hC0DE_0000_0000_000F);
        step();
        idle(); raddr_s[1][0] = 5'd2;
        #1;
        chk("nobyp_new_r2", rdata_b[63:0], 64'h0123_4567_89AB_CDEF);

        // Randomised traffic on both instances, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 2; k++) begin
                we0_s[k]     = 1'($urandom);
                we1_s[k]     = 1'($urandom);
                sb_set_s[k]  = ($urandom_range(0, 9) < 4);
                waddr0_s[k]  = rnd_addr(k);
                waddr1_s[k]  = rnd_addr(k);
                sb_addr_s[k] = rnd_addr(k);
                wdata0_s[k]  = (k == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
                wdata1_s[k]  = (k == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
                for (int p = 0; p < 4; p++) raddr_s[k][p] = rnd_addr(k);
            end
            step();
        end
        reset_n = 1'b1;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
